// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer:
// FSM encoding, prefetch entry layout and address checks.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam int unsigned ENTRY_W    = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Word index of a byte address compared against the memory size in words.
    function automatic logic word_in_range(input logic [31:0] addr, input logic [31:0] words);
        return ({2'b00, addr[31:2]} < words);
    endfunction

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of instruction-memory, redirect and decode-handshake signals.
// master = fetch sequencer, slave = surrounding pipeline / memory.
interface fetch_sequencer_if;
    logic [31:0] im_address;
    logic [31:0] im_instruction;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;
    logic        halted;
    logic        fault;

    modport master (
        output im_address,
        input  im_instruction,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instruction,
        output out_pc,
        output out_pcplus4,
        output halted,
        output fault
    );

    modport slave (
        input  im_address,
        output im_instruction,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instruction,
        input  out_pc,
        input  out_pcplus4,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry prefetch FIFO. Entry 0 is always the head, so the head outputs
// come straight from storage registers.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] push_data,
    output logic [1:0]         count,
    output logic               head_valid,
    output logic [31:0]        head_pc,
    output logic [31:0]        head_instr,
    output logic [31:0]        head_pcplus4
);

    fetch_entry_t in_s;
    fetch_entry_t e0_r;
    fetch_entry_t e1_r;
    logic [31:0]  pcp4_r;
    logic [1:0]   count_r;

    assign in_s = fetch_entry_t'(push_data);

    // FIFO storage and occupancy; pop shifts entry 1 into the head slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            e0_r    <= {ENTRY_W{1'b0}};
            e1_r    <= {ENTRY_W{1'b0}};
            pcp4_r  <= 32'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        e0_r   <= in_s;
                        pcp4_r <= in_s.pc + WORD_BYTES;
                    end else begin
                        e1_r   <= in_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    e0_r    <= e1_r;
                    pcp4_r  <= e1_r.pc + WORD_BYTES;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (count_r == 2'd1) begin
                        e0_r   <= in_s;
                        pcp4_r <= in_s.pc + WORD_BYTES;
                    end else begin
                        e0_r   <= e1_r;
                        pcp4_r <= e1_r.pc + WORD_BYTES;
                        e1_r   <= in_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign count        = count_r;
    assign head_valid   = (count_r != 2'd0);
    assign head_pc      = e0_r.pc;
    assign head_instr   = e0_r.instr;
    assign head_pcplus4 = pcp4_r;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns FetchPC, the FETCH/HALT/FAULT FSM and
// redirect handling, and feeds decode through a two-entry prefetch buffer.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 64,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master bus
);

    localparam logic [1:0]  DEPTH = 2'(BUF_DEPTH);
    localparam logic [31:0] WORDS = 32'(MEM_WORDS);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  fetch_pc_r;
    logic [31:0]  pc_nxt_s;
    logic [31:0]  pc_plus4_s;
    logic         fault_r;
    logic         fault_nxt_s;
    logic         halted_r;
    logic         halted_nxt_s;
    logic         push_s;
    logic         pop_s;
    logic         flush_s;
    logic [1:0]   count_s;
    logic [1:0]   count_nxt_s;
    logic         head_valid_s;

    assign pc_plus4_s = fetch_pc_r + WORD_BYTES;

    // Next-state, FetchPC and buffer control; redirect overrides everything but FAULT.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = fetch_pc_r;
        fault_nxt_s = fault_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        case (state_r)
            ST_FETCH, ST_HALT: begin
                if (bus.redirect) begin
                    flush_s = 1'b1;
                    if (!is_aligned(bus.redirect_pc)) begin
                        state_nxt_s = ST_FAULT;
                        fault_nxt_s = 1'b1;
                    end else if (word_in_range(bus.redirect_pc, WORDS)) begin
                        pc_nxt_s    = bus.redirect_pc;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        pc_nxt_s    = bus.redirect_pc;
                        state_nxt_s = ST_HALT;
                    end
                end else begin
                    pop_s = head_valid_s & bus.out_ready;
                    if (state_r != ST_FETCH) begin
                        state_nxt_s = ST_HALT;
                    end else if (!word_in_range(fetch_pc_r, WORDS)) begin
                        state_nxt_s = ST_HALT;
                    end else if ((count_s < DEPTH) || pop_s) begin
                        // Stepping past the last word halts; the range check also covers wrap.
                        push_s      = 1'b1;
                        pc_nxt_s    = pc_plus4_s;
                        state_nxt_s = word_in_range(pc_plus4_s, WORDS) ? ST_FETCH : ST_HALT;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
                fault_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_FAULT;
                fault_nxt_s = 1'b1;
                flush_s     = 1'b1;
            end
        endcase
    end

    // Predicted occupancy so Halted can be registered alongside the state.
    always_comb begin
        count_nxt_s = count_s;
        if (flush_s) begin
            count_nxt_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_s + 2'd1;
                2'b01:   count_nxt_s = count_s - 2'd1;
                default: count_nxt_s = count_s;
            endcase
        end
        halted_nxt_s = (state_nxt_s == ST_HALT) && (count_nxt_s == 2'd0);
    end

    // FSM state, fetch PC and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= RESET_PC;
            fault_r    <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= pc_nxt_s;
            fault_r    <= fault_nxt_s;
            halted_r   <= halted_nxt_s;
        end
    end

    fetch_skid_buffer u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push_s),
        .pop          (pop_s),
        .flush        (flush_s),
        .push_data    ({fetch_pc_r, bus.im_instruction}),
        .count        (count_s),
        .head_valid   (head_valid_s),
        .head_pc      (bus.out_pc),
        .head_instr   (bus.out_instruction),
        .head_pcplus4 (bus.out_pcplus4)
    );

    assign bus.im_address = fetch_pc_r;
    assign bus.out_valid  = head_valid_s;
    assign bus.halted     = halted_r;
    assign bus.fault      = fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory word i holds i*4, so every
// delivered instruction must equal its PC.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if bus();

    assign bus.im_instruction = {bus.im_address[31:2], 2'b00};

    fetch_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .MEM_WORDS (64),
        .BUF_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", bus.halted); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b want 0", bus.fault); end
        checks++; if (bus.out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", bus.out_pc); end
        checks++; if (bus.out_instruction !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.out_instruction); end
        checks++; if (bus.out_pcplus4 !== 32'd0) begin errors++; $display("FAIL reset_pcp4: got %h want 0", bus.out_pcplus4); end
        checks++; if (bus.im_address !== 32'd0) begin errors++; $display("FAIL reset_imaddr: got %h want 0", bus.im_address); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp = 32'(i) * 32'd4;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, bus.out_valid); end
            checks++; if (bus.out_pc !== exp) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.out_pc, exp); end
            checks++; if (bus.out_instruction !== exp) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.out_instruction, exp); end
            checks++; if (bus.out_pcplus4 !== exp + 32'd4) begin errors++; $display("FAIL stream_pcp4[%0d]: got %h want %h", i, bus.out_pcplus4, exp + 32'd4); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_reset();
        bus.out_ready = 1'b0;
        step();
        checks++; if (bus.im_address !== 32'd4) begin errors++; $display("FAIL bp_imaddr_first: got %h want 4", bus.im_address); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (bus.im_address !== 32'd8) begin errors++; $display("FAIL bp_imaddr_hold[%0d]: got %h want 8", k, bus.im_address); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0) begin errors++; $display("FAIL bp_head_hold[%0d]: got v=%0b pc=%h want v=1 pc=0", k, bus.out_valid, bus.out_pc); end
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            exp = 32'(k) * 32'd4;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp) begin errors++; $display("FAIL bp_drain[%0d]: got v=%0b pc=%h want v=1 pc=%h", k, bus.out_valid, bus.out_pc, exp); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.out_ready = 1'b0;
        step();
        step();
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_pc !== 32'd4 || bus.im_address !== 32'd12) begin errors++; $display("FAIL rd_setup: got pc=%h ima=%h want pc=4 ima=c", bus.out_pc, bus.im_address); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h20;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rd_bubble_valid: got %0b want 0", bus.out_valid); end
        checks++; if (bus.im_address !== 32'h20) begin errors++; $display("FAIL rd_imaddr: got %h want 20", bus.im_address); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h20) begin errors++; $display("FAIL rd_first: got v=%0b pc=%h want v=1 pc=20", bus.out_valid, bus.out_pc); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h24) begin errors++; $display("FAIL rd_second: got v=%0b pc=%h want v=1 pc=24", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_halt();
        logic [31:0] exp;
        do_reset();
        bus.out_ready = 1'b1;
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hF0;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.im_address !== 32'hF0) begin errors++; $display("FAIL halt_redirect: got v=%0b ima=%h want v=0 ima=f0", bus.out_valid, bus.im_address); end
        for (int k = 0; k < 4; k++) begin
            step();
            exp = 32'hF0 + 32'(k) * 32'd4;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== exp) begin errors++; $display("FAIL halt_tail[%0d]: got v=%0b pc=%h want v=1 pc=%h", k, bus.out_valid, bus.out_pc, exp); end
        end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL halt_draining: got %0b want 0", bus.halted); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_idle[%0d]: got h=%0b v=%0b want h=1 v=0", k, bus.halted, bus.out_valid); end
            checks++; if (bus.im_address !== 32'h100) begin errors++; $display("FAIL halt_imaddr[%0d]: got %h want 100", k, bus.im_address); end
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.halted !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_oor_redirect: got h=%0b v=%0b want h=1 v=0", bus.halted, bus.out_valid); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h4;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.halted !== 1'b0 || bus.im_address !== 32'h4) begin errors++; $display("FAIL halt_resume: got h=%0b ima=%h want h=0 ima=4", bus.halted, bus.im_address); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4) begin errors++; $display("FAIL halt_resume_pc: got v=%0b pc=%h want v=1 pc=4", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_fault();
        do_reset();
        bus.out_ready = 1'b1;
        step();
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h22;
        step();
        bus.redirect = 1'b0;
        checks++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fault_enter: got f=%0b v=%0b want f=1 v=0", bus.fault, bus.out_valid); end
        checks++; if (bus.im_address !== 32'h8) begin errors++; $display("FAIL fault_pc_hold: got %h want 8", bus.im_address); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fault_sticky[%0d]: got f=%0b v=%0b want f=1 v=0", k, bus.fault, bus.out_valid); end
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0;
        step();
        bus.redirect = 1'b0;
        step();
        checks++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.im_address !== 32'h8) begin errors++; $display("FAIL fault_ignore_redirect: got f=%0b v=%0b ima=%h want f=1 v=0 ima=8", bus.fault, bus.out_valid, bus.im_address); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.fault !== 1'b0 || bus.im_address !== 32'h0) begin errors++; $display("FAIL fault_reset: got f=%0b ima=%h want f=0 ima=0", bus.fault, bus.im_address); end
        #1;
        rst_n = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin errors++; $display("FAIL fault_restart: got v=%0b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.out_pc !== 32'h8) begin errors++; $display("FAIL async_setup: got %h want 8", bus.out_pc); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instruction !== 32'h0) begin errors++; $display("FAIL async_out: got v=%0b pc=%h ins=%h want 0 0 0", bus.out_valid, bus.out_pc, bus.out_instruction); end
        checks++; if (bus.out_pcplus4 !== 32'h0 || bus.im_address !== 32'h0 || bus.halted !== 1'b0) begin errors++; $display("FAIL async_misc: got p4=%h ima=%h h=%0b want 0 0 0", bus.out_pcplus4, bus.im_address, bus.halted); end
        #2;
        rst_n = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin errors++; $display("FAIL async_restart: got v=%0b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
        step();
        checks++; if (bus.out_pc !== 32'h4) begin errors++; $display("FAIL async_second: got %h want 4", bus.out_pc); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'd0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
